// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage request, mtc0/mfc0 and redirect signals between the pipeline and CP0.
`default_nettype none

interface cp0_unit_if #(
  parameter int NUM_HWINT = 6
);
  logic [31:0]          PC4M;
  logic                 BD_M;
  logic                 ValidM;
  logic [4:0]           ExcCode_M;
  logic [NUM_HWINT-1:0] HWInt;
  logic                 WE;
  logic [4:0]           Addr;
  logic [31:0]          WData;
  logic                 EretM;
  logic [31:0]          RData;
  logic [31:0]          EPC_out;
  logic                 EXL_out;
  logic                 Req;
  logic [31:0]          Vector;

  modport master (
    output PC4M, BD_M, ValidM, ExcCode_M, HWInt, WE, Addr, WData, EretM,
    input  RData, EPC_out, EXL_out, Req, Vector
  );

  modport slave (
    input  PC4M, BD_M, ValidM, ExcCode_M, HWInt, WE, Addr, WData, EretM,
    output RData, EPC_out, EXL_out, Req, Vector
  );
endinterface

`default_nettype wire

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 exception/interrupt arbiter and SR/Cause/EPC/PRId state beside the M stage.
// Optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
`default_nettype none

module cp0_unit #(
  parameter int          NUM_HWINT    = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h0000_0000
) (
  input  wire logic   Clk,
  input  wire logic   Reset,
  cp0_unit_if.slave   bus
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:2] epc;

  logic [5:0]  hw_pad;
  logic [5:0]  ip_next;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr_en;
  logic [31:0] epc_target;

  // Unused IP positions above NUM_HWINT are tied low.
  for (genvar i = 0; i < 6; i++) begin : g_ip
    if (i < NUM_HWINT) begin : g_line
      assign hw_pad[i] = bus.HWInt[i];
    end else begin : g_tie
      assign hw_pad[i] = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if (wr_en && bus.Addr == ADDR_COMPARE) begin
        compare <= bus.WData;
        ti      <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        ti <= 1'b1;
      end
    end
  end

  assign ip_next = {hw_pad[5:1], hw_pad[0] | ti};
`else
  assign ip_next = hw_pad;
`endif

  assign int_req    = sr_ie & ~sr_exl & (|(cause_ip & sr_im));
  assign exc_req    = ~sr_exl & (bus.ExcCode_M != 5'd0);
  assign req        = bus.ValidM & (int_req | exc_req);
  // A taken exception swallows any mtc0/eret sharing its cycle.
  assign wr_en      = bus.WE & ~req;
  assign epc_target = bus.PC4M - (bus.BD_M ? 32'd8 : 32'd4);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 30'd0;
    end else begin
      cause_ip <= ip_next;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.BD_M;
        cause_exc <= int_req ? 5'd0 : bus.ExcCode_M;
        epc       <= epc_target[31:2];
      end else begin
        if (wr_en && bus.Addr == ADDR_SR) begin
          sr_im  <= bus.WData[15:10];
          sr_exl <= bus.WData[1];
          sr_ie  <= bus.WData[0];
        end
        if (wr_en && bus.Addr == ADDR_EPC) begin
          epc <= bus.WData[31:2];
        end
        if (bus.EretM) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.RData = 32'd0;
    case (bus.Addr)
      ADDR_SR:    bus.RData = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      ADDR_CAUSE: bus.RData = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      // Same-cycle mtc0 to EPC is forwarded raw so a following mfc0 sees it.
      ADDR_EPC:   bus.RData = wr_en ? bus.WData : {epc, 2'b00};
      ADDR_PRID:  bus.RData = PRID;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   bus.RData = count;
      ADDR_COMPARE: bus.RData = compare;
`endif
      default:    bus.RData = 32'd0;
    endcase
  end

  assign bus.EPC_out = {epc, 2'b00};
  assign bus.EXL_out = sr_exl;
  assign bus.Req     = req;
  assign bus.Vector  = HANDLER_ADDR;

endmodule

`default_nettype wire

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed checks of cp0_unit arbitration, commit, eret, bypass and reset.
`default_nettype none

module tb_cp0_unit;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_pass;

  cp0_unit_if #(.NUM_HWINT(6)) bus ();

  cp0_unit #(
    .NUM_HWINT   (6),
    .HANDLER_ADDR(32'h0000_4180),
    .PRID        (32'h0000_0000)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.Addr = a;
    settle();
    chk(tag, bus.RData, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset = 1'b1;
    bus.PC4M = 32'd0; bus.BD_M = 1'b0; bus.ValidM = 1'b0; bus.ExcCode_M = 5'd0;
    bus.HWInt = 6'd0; bus.WE = 1'b0; bus.Addr = 5'd0; bus.WData = 32'd0; bus.EretM = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    settle();

    chk("rst_req", {31'd0, bus.Req}, 32'd0);
    chk("rst_exl", {31'd0, bus.EXL_out}, 32'd0);
    chk("rst_epc", bus.EPC_out, 32'd0);
    chk("vector", bus.Vector, 32'h0000_4180);
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_prid", 5'd15, 32'd0);
    rd("rst_addr9", 5'd9, 32'd0);

    // Enable all IM lines and IE.
    bus.WE = 1'b1; bus.Addr = 5'd12; bus.WData = 32'h0000_FC01;
    tick();
    bus.WE = 1'b0;
    rd("sr_wr", 5'd12, 32'h0000_FC01);

    // Interrupt on line 2: one cycle through IP before Req.
    bus.HWInt = 6'b000100; bus.ValidM = 1'b1; bus.PC4M = 32'h0000_3008;
    settle();
    chk("int_lat0", {31'd0, bus.Req}, 32'd0);
    tick();
    chk("int_req", {31'd0, bus.Req}, 32'd1);
    tick();
    chk("int_epc", bus.EPC_out, 32'h0000_3004);
    chk("int_exl", {31'd0, bus.EXL_out}, 32'd1);
    rd("int_cause", 5'd13, 32'h0000_1000);
    chk("exl_block", {31'd0, bus.Req}, 32'd0);

    // Held line stays blocked by EXL, then fires after eret.
    tick();
    chk("exl_block2", {31'd0, bus.Req}, 32'd0);
    bus.EretM = 1'b1;
    tick();
    bus.EretM = 1'b0;
    settle();
    chk("eret_exl", {31'd0, bus.EXL_out}, 32'd0);
    chk("eret_refire", {31'd0, bus.Req}, 32'd1);
    bus.ValidM = 1'b0;
    settle();
    chk("bubble_hold", {31'd0, bus.Req}, 32'd0);
    tick();
    chk("bubble_nochg", {31'd0, bus.EXL_out}, 32'd0);
    bus.HWInt = 6'd0;
    tick();
    bus.ValidM = 1'b1;
    settle();
    chk("idle_req", {31'd0, bus.Req}, 32'd0);

    // AdEL exception from a delay slot.
    bus.ExcCode_M = 5'd4; bus.BD_M = 1'b1; bus.PC4M = 32'h0000_3010;
    settle();
    chk("exc_req", {31'd0, bus.Req}, 32'd1);
    tick();
    bus.ExcCode_M = 5'd0; bus.BD_M = 1'b0;
    chk("exc_epc", bus.EPC_out, 32'h0000_3008);
    rd("exc_cause", 5'd13, 32'h8000_0010);
    bus.EretM = 1'b1;
    tick();
    bus.EretM = 1'b0;
    settle();
    chk("exc_eret", {31'd0, bus.EXL_out}, 32'd0);

    // Interrupt and exception together, with a colliding mtc0 to EPC.
    bus.HWInt = 6'b000100; bus.ValidM = 1'b0;
    tick();
    bus.ValidM = 1'b1; bus.ExcCode_M = 5'd10; bus.PC4M = 32'h0000_5000;
    bus.WE = 1'b1; bus.Addr = 5'd14; bus.WData = 32'hDEAD_BEE0;
    settle();
    chk("prio_req", {31'd0, bus.Req}, 32'd1);
    tick();
    bus.WE = 1'b0; bus.ExcCode_M = 5'd0; bus.ValidM = 1'b0; bus.HWInt = 6'd0;
    chk("prio_epc", bus.EPC_out, 32'h0000_4FFC);
    rd("prio_cause", 5'd13, 32'h0000_1000);
    bus.EretM = 1'b1;
    tick();
    bus.EretM = 1'b0;
    tick();

    // EPC write bypass and [1:0] masking.
    bus.WE = 1'b1; bus.Addr = 5'd14; bus.WData = 32'h0000_3ABD;
    settle();
    chk("epc_bypass", bus.RData, 32'h0000_3ABD);
    tick();
    bus.WE = 1'b0;
    rd("epc_rd", 5'd14, 32'h0000_3ABC);
    chk("epc_out", bus.EPC_out, 32'h0000_3ABC);

    // Cause is read-only.
    bus.WE = 1'b1; bus.Addr = 5'd13; bus.WData = 32'hFFFF_FFFF;
    tick();
    bus.WE = 1'b0;
    rd("cause_ro", 5'd13, 32'h0000_0000);

    // Reset beats a pending Req.
    bus.HWInt = 6'b000001;
    tick();
    bus.ValidM = 1'b1;
    settle();
    chk("pre_rst_req", {31'd0, bus.Req}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; bus.HWInt = 6'd0; bus.ValidM = 1'b0;
    settle();
    chk("mid_rst_exl", {31'd0, bus.EXL_out}, 32'd0);
    chk("mid_rst_epc", bus.EPC_out, 32'd0);
    rd("mid_rst_sr", 5'd12, 32'd0);

`ifdef CP0_TIMER_EN
    begin
      logic found;
      found = 1'b0;
      bus.WE = 1'b1; bus.Addr = 5'd12; bus.WData = 32'h0000_0401;
      tick();
      bus.Addr = 5'd11; bus.WData = 32'd5;
      tick();
      bus.WE = 1'b0; bus.ValidM = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
        settle();
        if (bus.Req) found = 1'b1;
        else tick();
      end
      chk("timer_req", {31'd0, found}, 32'd1);
      tick();
      bus.ValidM = 1'b0;
      bus.WE = 1'b1; bus.Addr = 5'd11; bus.WData = 32'd0; bus.EretM = 1'b1;
      tick();
      bus.WE = 1'b0; bus.EretM = 1'b0;
      tick();
      bus.ValidM = 1'b1;
      settle();
      chk("timer_ti_clr", {31'd0, bus.Req}, 32'd0);
      rd("timer_cmp", 5'd11, 32'd0);
    end
`else
    bus.WE = 1'b1; bus.Addr = 5'd9; bus.WData = 32'h1234_5678;
    tick();
    bus.WE = 1'b0;
    rd("no_timer_9", 5'd9, 32'd0);
    rd("no_timer_11", 5'd11, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_unit.md
# cp0_unit

Parametrised coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It sits beside the M stage. It arbitrates between the M-stage exception code and NUM_HWINT external interrupt lines, then commits the architectural SR/Cause/EPC state and raises a flush/redirect request to the fetch logic. It generalises the fixed six-line controller: the line count and PRId are configurable, request validity is qualified by the M-stage valid bit, and an optional Count/Compare timer is provided.

## Interface
Parameters:
- NUM_HWINT, 6, number of external interrupt lines, legal range 1..6, mapped to IP/IM bits [10 +: NUM_HWINT]
- HANDLER_ADDR, 32'h0000_4180, redirect target driven on Vector
- PRID, 32'h0000_0000, constant value read from PRId

Ports:
- Clk  input  1  system clock; one clock, all state on rising edge
- Reset  input  1  synchronous, active-high
- PC4M  input  32  PC+4 of the M-stage instruction
- BD_M  input  1  M-stage instruction is in a delay slot
- ValidM  input  1  M stage holds a real instruction (not a bubble)
- ExcCode_M  input  5  M-stage exception code; 0 = none
- HWInt  input  NUM_HWINT  level-sensitive external interrupt lines
- WE  input  1  mtc0 write in M stage
- Addr  input  5  CP0 register number for mtc0/mfc0
- WData  input  32  mtc0 data
- EretM  input  1  eret in M stage
- RData  output  32  mfc0 read data (combinational)
- EPC_out  output  32  current EPC
- EXL_out  output  1  SR.EXL
- Req  output  1  take exception/interrupt this cycle (flush F/D/E/M, redirect)
- Vector  output  32  constant HANDLER_ADDR

## Operation
- Registers: SR (12): IM[15:10], EXL[1], IE[0]. Cause (13): BD[31], IP[15:10] read-only, ExcCode[6:2]. EPC (14). PRId (15). Count (9) and Compare (11) exist only with the timer. All other bits read 0.
- IP capture: IP[10+i] <= HWInt[i] every cycle. With the timer, IP[10] <= HWInt[0] | TI.
- IntReq = IE & ~EXL & |(IP & IM). ExcReq = ~EXL & (ExcCode_M != 0). Req = ValidM & (IntReq | ExcReq).
- Priority: interrupt over exception. On an interrupt, Cause.ExcCode <= 0. On an exception, Cause.ExcCode <= ExcCode_M.
- Commit on Req: EXL <= 1, Cause.BD <= BD_M, and EPC <= (PC4M − 4) when BD_M=0 or (PC4M − 8) when BD_M=1. EPC[1:0] is forced to 0 when the value is written.
- While Req is asserted, mtc0 (WE) and eret (EretM) in the same cycle are suppressed; the exception wins.
- EretM without Req: EXL <= 0 on the next edge.
- mtc0 writes: SR writes IM/EXL/IE; EPC writes bits [31:2]; Cause, PRId and Count are read-only (writes ignored).
- RData is selected by Addr. Unimplemented registers read 0. A read of EPC in the same cycle as a write to EPC returns WData (bypass).

## Timing
- Reset values: SR=0, Cause=0, EPC=0, Count=0, Compare=0, TI=0. Outputs after reset: RData=0 for all addresses except PRId, EPC_out=0, EXL_out=0, Req=0.
- Req is combinational from the registered IP and the current-cycle M-stage inputs. State updates on the following rising edge.
- HWInt-to-Req latency is one cycle, through the IP register.
- Holding EXL=1 blocks a second Req until eret. A pending line stays visible in IP and fires on the first valid cycle after EXL clears.
- If ValidM=0 while an interrupt is pending, Req is held off until ValidM=1. No state changes in the meantime.
- Reset asserted mid-operation wins over Req, WE and EretM in the same cycle.

## Configuration
- CP0_TIMER_EN defined:
  - Count increments every cycle and wraps at 2^32.
  - When Count == Compare and Compare != 0, TI <= 1. TI is sticky.
  - An mtc0 write to Compare clears TI and loads Compare.
- CP0_TIMER_EN undefined: no Count/Compare/TI state; addresses 9 and 11 read 0; writes to them are ignored; IP[10] = HWInt[0].

## Test plan
- NUM_HWINT=6; SR=32'h0000_FC01; HWInt=6'b000100 at cycle t with ValidM=1 and PC4M=32'h3008 -> Req=1 at t+1. Then EPC=32'h3004, Cause.ExcCode=0, Cause.IP=6'b000100, EXL=1.
- ExcCode_M=5'd4 (AdEL), BD_M=1, PC4M=32'h3010, EXL=0 -> Req=1 the same cycle. Then EPC=32'h3008, Cause=32'h8000_0010.
- Interrupt pending and ExcCode_M=5'd10 in the same cycle -> interrupt wins; ExcCode=0. A concurrent mtc0 to EPC is ignored.
- EXL=1 with HWInt held high -> Req stays 0. EretM=1 -> EXL=0 next edge, and Req=1 on the following valid cycle.
- With CP0_TIMER_EN: Compare=5, IM[10]=1, IE=1 -> Req when Count reaches 5. An mtc0 to Compare clears TI. Without the macro, a read of address 9 returns 0.
- mtc0 EPC=32'h0000_3ABD with a same-cycle mfc0 EPC -> RData=32'h0000_3ABD (bypass). The register then reads 32'h0000_3ABC.
